// File: rtl/geofence_pkg.sv
// rtl/geofence_pkg.sv - shared state encoding, width helpers and sort schedule for geofence_judge
package geofence_pkg;
  localparam int GEO_CW     = 10;
  localparam int NUM_PTS    = 6;
  localparam int NUM_PASSES = 4;

  // Compares per bubble pass over P1..P5; each pass settles one more tail element.
  localparam logic [2:0] PASS_LEN [NUM_PASSES] = '{3'd4, 3'd3, 3'd2, 3'd1};

  typedef enum logic [1:0] {ST_IDLE, ST_SORT, ST_CHECK, ST_DONE} state_e;

  typedef struct packed {
    logic [GEO_CW-1:0] x;
    logic [GEO_CW-1:0] y;
  } point_t;

  function automatic int diff_w(input int cw);
    return cw + 1;
  endfunction

  function automatic int cross_w(input int cw);
    return 2 * cw + 3;
  endfunction
endpackage

// File: rtl/geo_cross.sv
// rtl/geo_cross.sv - signed 2-D cross product (a - org) x (b - org), exact at full width
module geo_cross
  import geofence_pkg::*;
#(
  parameter int CW = GEO_CW
) (
  input  logic        [2*CW-1:0]        org_i,
  input  logic        [2*CW-1:0]        a_i,
  input  logic        [2*CW-1:0]        b_i,
  output logic signed [cross_w(CW)-1:0] cross_o
);
  localparam int DW = diff_w(CW);
  localparam int PW = 2 * DW;

  logic signed [DW-1:0] ax, ay, bx, by;
  logic signed [PW-1:0] axe, aye, bxe, bye, p_ab, p_ba;

  assign ax = $signed({1'b0, a_i[2*CW-1:CW]}) - $signed({1'b0, org_i[2*CW-1:CW]});
  assign ay = $signed({1'b0, a_i[CW-1:0]})    - $signed({1'b0, org_i[CW-1:0]});
  assign bx = $signed({1'b0, b_i[2*CW-1:CW]}) - $signed({1'b0, org_i[2*CW-1:CW]});
  assign by = $signed({1'b0, b_i[CW-1:0]})    - $signed({1'b0, org_i[CW-1:0]});

  // Widen before multiplying so the product never wraps.
  assign axe = {{DW{ax[DW-1]}}, ax};
  assign aye = {{DW{ay[DW-1]}}, ay};
  assign bxe = {{DW{bx[DW-1]}}, bx};
  assign bye = {{DW{by[DW-1]}}, by};

  assign p_ab = axe * bye;
  assign p_ba = bxe * aye;

  assign cross_o = {p_ab[PW-1], p_ab} - {p_ba[PW-1], p_ba};
endmodule

// File: rtl/geofence_judge.sv
// rtl/geofence_judge.sv - orders fence vertices around G1, then tests the object against every edge
// Optional GEOFENCE_SORT_EARLY_EXIT_EN: SORT ends after the first pass that makes no swap.
module geofence_judge
  import geofence_pkg::*;
#(
  parameter int CW = GEO_CW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2*CW-1:0] obj,
  input  logic [2*CW-1:0] g1,
  input  logic [2*CW-1:0] g2,
  input  logic [2*CW-1:0] g3,
  input  logic [2*CW-1:0] g4,
  input  logic [2*CW-1:0] g5,
  input  logic [2*CW-1:0] g6,
  output logic            busy,
  output logic            valid,
  output logic            is_inside
);
  localparam int XW = cross_w(CW);
  localparam logic signed [XW-1:0] ZERO = '0;
  localparam logic [1:0] LAST_PASS = 2'(NUM_PASSES - 1);

  state_e          state_q, state_d;
  logic [2*CW-1:0] pts_q [NUM_PTS];
  logic [2*CW-1:0] obj_q;
  logic [1:0]      pass_q;
  logic [2:0]      k_q, i_q;
  logic            all_pos_q, all_neg_q, inside_q;

  logic signed [XW-1:0] sort_cross, edge_cross;
  logic [2:0] ka, kb, ib;
  logic       swap, pass_end, sort_done, edge_pos, edge_neg;

  assign ka = k_q + 3'd1;
  assign kb = k_q + 3'd2;
  assign ib = (i_q == 3'd5) ? 3'd0 : i_q + 3'd1;

  geo_cross #(.CW(CW)) u_sort_cross (
    .org_i  (pts_q[0]),
    .a_i    (pts_q[ka]),
    .b_i    (pts_q[kb]),
    .cross_o(sort_cross)
  );

  geo_cross #(.CW(CW)) u_edge_cross (
    .org_i  (obj_q),
    .a_i    (pts_q[i_q]),
    .b_i    (pts_q[ib]),
    .cross_o(edge_cross)
  );

  assign swap     = sort_cross < ZERO;
  assign edge_pos = edge_cross > ZERO;
  assign edge_neg = edge_cross < ZERO;
  assign pass_end = (k_q == PASS_LEN[pass_q] - 3'd1);

`ifdef GEOFENCE_SORT_EARLY_EXIT_EN
  logic swapped_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      swapped_q <= 1'b0;
    end else if (state_q != ST_SORT || pass_end) begin
      swapped_q <= 1'b0;
    end else if (swap) begin
      swapped_q <= 1'b1;
    end
  end

  assign sort_done = pass_end && (pass_q == LAST_PASS || !(swapped_q || swap));
`else
  assign sort_done = pass_end && (pass_q == LAST_PASS);
`endif

  always_comb begin
    state_d   = state_q;
    busy      = (state_q != ST_IDLE);
    valid     = (state_q == ST_DONE);
    is_inside = inside_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_SORT;
      ST_SORT:  if (sort_done) state_d = ST_CHECK;
      ST_CHECK: if (i_q == 3'd5) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < NUM_PTS; n++) pts_q[n] <= '0;
      obj_q     <= '0;
      pass_q    <= '0;
      k_q       <= '0;
      i_q       <= '0;
      all_pos_q <= 1'b0;
      all_neg_q <= 1'b0;
      inside_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            pts_q[0]  <= g1;
            pts_q[1]  <= g2;
            pts_q[2]  <= g3;
            pts_q[3]  <= g4;
            pts_q[4]  <= g5;
            pts_q[5]  <= g6;
            obj_q     <= obj;
            pass_q    <= '0;
            k_q       <= '0;
            i_q       <= '0;
            all_pos_q <= 1'b1;
            all_neg_q <= 1'b1;
            inside_q  <= 1'b0;
          end
        end
        ST_SORT: begin
          if (swap) begin
            pts_q[ka] <= pts_q[kb];
            pts_q[kb] <= pts_q[ka];
          end
          if (pass_end) begin
            pass_q <= pass_q + 2'd1;
            k_q    <= '0;
          end else begin
            k_q <= k_q + 3'd1;
          end
        end
        ST_CHECK: begin
          // A zero cross product clears both flags, so edge hits count as outside.
          i_q       <= ib;
          all_pos_q <= all_pos_q & edge_pos;
          all_neg_q <= all_neg_q & edge_neg;
          if (i_q == 3'd5) inside_q <= (all_pos_q & edge_pos) | (all_neg_q & edge_neg);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_geofence_judge.sv
// tb/tb_geofence_judge.sv - table, hand-written and randomized checks of geofence_judge
module tb_geofence_judge;
  localparam int CW = 10;
  localparam real PI = 3.14159265358979;
`ifdef GEOFENCE_SORT_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef logic [5:0][2*CW-1:0] fence_t;
  typedef struct {
    fence_t          g;
    logic [2*CW-1:0] o;
    logic            exp_in;
  } vec_t;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [2*CW-1:0] obj = '0, g1 = '0, g2 = '0, g3 = '0, g4 = '0, g5 = '0, g6 = '0;
  logic busy, valid, is_inside;
  int checks = 0, errors = 0;

  geofence_judge #(.CW(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .obj(obj),
    .g1(g1), .g2(g2), .g3(g3), .g4(g4), .g5(g5), .g6(g6),
    .busy(busy), .valid(valid), .is_inside(is_inside)
  );

  always #5 clk = ~clk;

  function automatic logic [2*CW-1:0] pt(input int x, input int y);
    return {x[CW-1:0], y[CW-1:0]};
  endfunction

  function automatic fence_t hex6(input logic [2*CW-1:0] a, b, c, d, e, f);
    return {f, e, d, c, b, a};
  endfunction

  // Inside test from first principles: order vertices by angle about their centroid.
  function automatic logic model_inside(input fence_t g, input logic [2*CW-1:0] o);
    real cx = 0.0, cy = 0.0, ang[6], tr;
    int idx[6], ti, np = 0, nn = 0;
    longint ox = longint'(o[2*CW-1:CW]), oy = longint'(o[CW-1:0]);
    for (int i = 0; i < 6; i++) begin
      cx += real'(g[i][2*CW-1:CW]) / 6.0;
      cy += real'(g[i][CW-1:0]) / 6.0;
    end
    for (int i = 0; i < 6; i++) begin
      ang[i] = $atan2(real'(g[i][CW-1:0]) - cy, real'(g[i][2*CW-1:CW]) - cx);
      idx[i] = i;
    end
    for (int i = 0; i < 5; i++)
      for (int j = i + 1; j < 6; j++)
        if (ang[j] < ang[i]) begin
          tr = ang[i]; ang[i] = ang[j]; ang[j] = tr;
          ti = idx[i]; idx[i] = idx[j]; idx[j] = ti;
        end
    for (int i = 0; i < 6; i++) begin
      longint ax = longint'(g[idx[i]][2*CW-1:CW]) - ox, ay = longint'(g[idx[i]][CW-1:0]) - oy;
      longint bx = longint'(g[idx[(i+1)%6]][2*CW-1:CW]) - ox, by = longint'(g[idx[(i+1)%6]][CW-1:0]) - oy;
      longint c = ax * by - bx * ay;
      if (c > 0) np++;
      else if (c < 0) nn++;
    end
    return (np == 6) || (nn == 6);
  endfunction

  // Cycles from start to valid: compares executed by the bubble schedule plus CHECK and DONE.
  function automatic int model_latency(input fence_t g);
    longint x[6], y[6], t;
    int n = 0;
    bit sw;
    for (int i = 0; i < 6; i++) begin
      x[i] = longint'(g[i][2*CW-1:CW]);
      y[i] = longint'(g[i][CW-1:0]);
    end
    for (int p = 0; p < 4; p++) begin
      sw = 1'b0;
      for (int k = 1; k <= 4 - p; k++) begin
        longint c = (x[k] - x[0]) * (y[k+1] - y[0]) - (x[k+1] - x[0]) * (y[k] - y[0]);
        n++;
        if (c < 0) begin
          t = x[k]; x[k] = x[k+1]; x[k+1] = t;
          t = y[k]; y[k] = y[k+1]; y[k+1] = t;
          sw = 1'b1;
        end
      end
      if (EARLY && !sw) break;
    end
    return n + 7;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic run_job(input fence_t g, input logic [2*CW-1:0] o, input int repulse_at,
                         output int lat, output int np, output int bc, output logic ins);
    @(posedge clk); #1;
    {g6, g5, g4, g3, g2, g1} = g;
    obj   = o;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    obj   = ~o;
    g1    = ~g1;
    lat = -1; np = 0; bc = 0; ins = 1'bx;
    for (int c = 1; c <= 24; c++) begin
      if (busy) bc++;
      if (valid) begin
        np++;
        if (lat < 0) begin lat = c; ins = is_inside; end
      end
      if (c == repulse_at) begin
        start = 1'b1;
        obj   = pt(300, 100);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic check_job(input string nm, input fence_t g, input int lat, input int np,
                           input int bc, input logic ins, input logic exp_in);
    int el = model_latency(g);
    chk({nm, " latency"}, lat, el);
    chk({nm, " pulses"}, np, 1);
    chk({nm, " busy_cycles"}, bc, el);
    chk({nm, " is_inside"}, ins, exp_in);
    chk({nm, " held"}, is_inside, exp_in);
  endtask

  initial begin
    vec_t tbl[$];
    vec_t v;
    fence_t scr, srt, rev, cor, rg;
    logic [2*CW-1:0] tmp, o;
    int lat, np, bc, r, cx, cy, vcnt;
    logic ins;
    real base, a;

    scr = hex6(pt(100,0), pt(100,200), pt(250,100), pt(50,100), pt(200,0), pt(200,200));
    srt = hex6(pt(100,0), pt(200,0), pt(250,100), pt(200,200), pt(100,200), pt(50,100));
    rev = hex6(pt(100,0), pt(50,100), pt(100,200), pt(200,200), pt(250,100), pt(200,0));
    cor = hex6(pt(0,0), pt(1023,1023), pt(0,700), pt(1023,300), pt(700,0), pt(300,1023));
    v.g = scr; v.o = pt(150,100); v.exp_in = 1'b1; tbl.push_back(v);
    v.g = scr; v.o = pt(300,100); v.exp_in = 1'b0; tbl.push_back(v);
    v.g = scr; v.o = pt(150,0);   v.exp_in = 1'b0; tbl.push_back(v);
    v.g = srt; v.o = pt(150,100); v.exp_in = 1'b1; tbl.push_back(v);
    v.g = rev; v.o = pt(150,100); v.exp_in = 1'b1; tbl.push_back(v);
    v.g = cor; v.o = pt(512,512); v.exp_in = 1'b1; tbl.push_back(v);
    v.g = cor; v.o = pt(0,0);     v.exp_in = 1'b0; tbl.push_back(v);
    v.g = cor; v.o = pt(1023,0);  v.exp_in = 1'b0; tbl.push_back(v);

    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", busy, 0);
    chk("reset valid", valid, 0);
    chk("reset is_inside", is_inside, 0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      run_job(tbl[i].g, tbl[i].o, 0, lat, np, bc, ins);
      check_job($sformatf("vec%0d", i), tbl[i].g, lat, np, bc, ins, tbl[i].exp_in);
    end

    chk("fixed latency scrambled", model_latency(scr), EARLY ? model_latency(scr) : 17);
    chk("presorted latency", model_latency(srt), EARLY ? 11 : 17);

    run_job(scr, pt(150,100), 5, lat, np, bc, ins);
    check_job("repulse", scr, lat, np, bc, ins, 1'b1);

    @(posedge clk); #1;
    {g6, g5, g4, g3, g2, g1} = scr;
    obj   = pt(150,100);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort busy", busy, 0);
    chk("abort valid", valid, 0);
    chk("abort is_inside", is_inside, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    vcnt = 0;
    for (int c = 0; c < 25; c++) begin
      if (valid) vcnt++;
      @(posedge clk); #1;
    end
    chk("abort no pulse", vcnt, 0);
    run_job(scr, pt(150,100), 0, lat, np, bc, ins);
    check_job("after_abort", scr, lat, np, bc, ins, 1'b1);

    for (int t = 0; t < 30; t++) begin
      r    = int'($urandom_range(100, 400));
      cx   = int'($urandom_range(r + 2, 1021 - r));
      cy   = int'($urandom_range(r + 2, 1021 - r));
      base = real'($urandom_range(0, 359));
      for (int i = 0; i < 6; i++) begin
        a = (base + 60.0 * i + real'($urandom_range(0, 30)) - 15.0) * PI / 180.0;
        rg[i] = pt($rtoi(cx + r * $cos(a) + 0.5), $rtoi(cy + r * $sin(a) + 0.5));
      end
      for (int i = 5; i > 0; i--) begin
        int j = int'($urandom_range(0, i));
        tmp = rg[i]; rg[i] = rg[j]; rg[j] = tmp;
      end
      o = pt(cx + int'($urandom_range(0, 2 * r)) - r, cy + int'($urandom_range(0, 2 * r)) - r);
      run_job(rg, o, 0, lat, np, bc, ins);
      check_job($sformatf("rand%0d", t), rg, lat, np, bc, ins, model_inside(rg, o));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/geofence_judge.md
Name: geofence_judge

Overview:
- Downstream stage of the point-load block. Consumes the captured object point plus six fence vertices and a one-cycle load-complete pulse.
- Orders vertices G2..G6 angularly around G1 using a sequential bubble sort driven by cross products.
- Tests whether the object lies strictly inside the convex hexagon, then reports the result with a one-cycle valid pulse.

Parameters:
- CW, 10, coordinate width per axis (X and Y each CW bits, unsigned)

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse from the load stage's finish signal; inputs are stable when it is high
- obj  in  2*CW  object point, [2CW-1:CW]=X, [CW-1:0]=Y
- g1..g6  in  2*CW each  fence vertices, same packing, unordered
- busy  out  1  high from the cycle after start is accepted until the DONE cycle, inclusive
- valid  out  1  one-cycle pulse; result is available
- is_inside  out  1  1 = object strictly inside the fence; held until the next accepted start

Behaviour:
- Reset: state IDLE; busy=0, valid=0, is_inside=0; internal point registers cleared.
- States: IDLE, SORT, CHECK, DONE.
  - IDLE: when start=1, capture P0..P5 from g1..g6 and O from obj; go to SORT. start in any other state is ignored.
  - SORT: 10 compare cycles using a shrinking bubble sort over P1..P5. Pass lengths are 4, 3, 2, 1. Pass p compares pairs (k,k+1) for k=1..5-p.
    - Pair rule: swap Pk and Pk+1 when cross(Pk-P0, Pk+1-P0) < 0.
    - One compare/swap per cycle. After the last compare go to CHECK.
  - CHECK: 6 cycles, i=0..5. Compute ci = cross(Pi-O, P((i+1) mod 6)-O).
    - Track all_pos (every ci>0) and all_neg (every ci<0) flags.
    - On the 6th cycle, register is_inside = all_pos | all_neg. Go to DONE.
  - DONE: valid=1 for exactly one cycle, then IDLE.
- Latency: start high in cycle n gives SORT in n+1..n+10, CHECK in n+11..n+16, and valid in n+17. The next start is accepted from n+18.
- valid and busy are decoded from the registered state. is_inside is a registered output.
- Arithmetic:
  - Differences are sign-extended to CW+1 bits.
  - Products are 2CW+2 bits; cross = ax*by - bx*ay in 2CW+3 bits, signed.
  - No truncation anywhere.
- Boundary: any ci == 0 (object on an edge or collinear with a vertex) clears both flags, so is_inside=0.
- Duplicate vertices giving cross=0 in SORT cause no swap; the result is then undefined but deterministic.
- Reset mid-operation: immediate return to IDLE with all outputs cleared; no valid pulse for the aborted job.

Optional Feature:
- Macro: GEOFENCE_SORT_EARLY_EXIT_EN.
  - Defined: a swapped flag is kept per pass. A pass that completes with no swap ends SORT immediately and enters CHECK. Latency becomes variable, with a minimum of n+11 for already-sorted input (one pass of 4 compares). busy covers the full duration.
  - Undefined: fixed 10-cycle SORT as above.

Decomposition:
- Package geofence_pkg holds:
  - state encodings (IDLE/SORT/CHECK/DONE)
  - CW-derived widths (DIFF_W=CW+1, CROSS_W=2CW+3)
  - the sort schedule constants (pass lengths 4,3,2,1)
  - a point typedef (x,y) if the language level allows
- One natural sub-module: geo_cross, combinational. Inputs are an origin and two points; output is the signed CROSS_W cross product.
  - Instantiated twice: once for the SORT pair and once for the CHECK edge, or shared through a mux.

Test Plan:
- Hexagon vertices (100,0),(200,0),(250,100),(200,200),(100,200),(50,100), fed scrambled as g1=(100,0), g2=(100,200), g3=(250,100), g4=(50,100), g5=(200,0), g6=(200,200). obj=(150,100) -> valid in cycle n+17, is_inside=1.
- Same fence, obj=(300,100) -> is_inside=0. obj=(150,0) lies on an edge -> is_inside=0.
- Same fence with g2..g6 already in CCW order, then in reversed order, obj=(150,100) -> is_inside=1 both times.
  - Without the macro, valid lands at n+17 in both cases.
  - With GEOFENCE_SORT_EARLY_EXIT_EN, pre-sorted input gives valid at n+11.
- start re-pulsed at n+5 with different data -> ignored; the result matches the first job and exactly one valid pulse occurs.
- reset asserted at n+12 (during CHECK) -> busy=0, valid=0, is_inside=0 immediately, with no valid pulse. A fresh start afterwards completes normally.
- Corner coordinates: fence at the (0,0)/(1023,1023) extremes with obj=(512,512) -> is_inside=1, confirming no overflow at full CW range.
